adc_c2h_packer: RTL

Packs ADC sample sets from the AD4003 acquisition path (channel A and channel B data arrays) into fixed-length AXI-Stream packets for the XDMA C2H channel 0. Each packet has one 128-bit header beat followed by two payload beats per sample set. The block sits between `adc_block` and the XDMA `s_axis_c2h_*_0` port in the `axi_aclk` domain. Sample arrays and their strobe arrive already synchronised to `axi_aclk`.

---
 rtl/adc_c2h_pkg.sv | 9 +
 rtl/adc_c2h_packer_fifo.sv | 62 ++++++
 rtl/adc_c2h_packer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/adc_c2h_pkg.sv
// Shared constants and FSM encoding for the ADC-to-C2H stream packer.
package adc_c2h_pkg;

  localparam logic [31:0] HDR_MAGIC = 32'h5348_4150;
  localparam int          WORD_W    = 32;

  typedef enum logic [1:0] {IDLE, HDR, PAY_A, PAY_B} pk_state_t;

endpackage

// File: rtl/adc_c2h_packer_fifo.sv
// Synchronous first-word-fall-through FIFO holding complete A/B sample sets.
// Also exposes the low PEEK_W bits of the entry behind the head.
module sample_fifo #(
  parameter int W      = 144,
  parameter int DEPTH  = 16,
  parameter int PEEK_W = 72
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  output logic [W-1:0]      rd_data,
  output logic [PEEK_W-1:0] rd_peek,
  output logic              full,
  output logic              empty,
  output logic              more_than_one
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic [AW-1:0] peek_idx;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  assign level         = wr_ptr_q - rd_ptr_q;
  assign full          = (level == FULL_LVL);
  assign empty         = (level == '0);
  assign more_than_one = (level > (AW+1)'(1));
  assign peek_idx      = rd_ptr_q[AW-1:0] + AW'(1);
  assign rd_data       = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_peek       = mem_q[peek_idx][PEEK_W-1:0];

  // A write into the slot being popped is safe: the read uses the old contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/adc_c2h_packer.sv
// Packs A/B ADC sample sets into header + payload AXI-Stream packets for XDMA C2H.
// state | meaning
// IDLE  | no packet in flight, waiting for a buffered set
// HDR   | header beat presented
// PAY_A | channel-A beat of the head set (tvalid low while waiting for data)
// PAY_B | channel-B beat of the head set; head pops on its handshake
module adc_c2h_packer
  import adc_c2h_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 18,
  parameter int N_ADC_CHANNELS = 4,
  parameter int C_DATA_WIDTH   = 128,
  parameter int PKT_SAMPLES    = 64,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                                     axi_aclk,
  input  logic                                     rst,
  input  logic                                     acq_en,
  input  logic                                     sample_valid,
  input  logic [ADC_DATA_WIDTH*N_ADC_CHANNELS-1:0] adc_a_data_arr,
  input  logic [ADC_DATA_WIDTH*N_ADC_CHANNELS-1:0] adc_b_data_arr,
  input  logic                                     ovf_clr,
  output logic [C_DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]                m_axis_tkeep,
  output logic                                     m_axis_tvalid,
  output logic                                     m_axis_tlast,
  input  logic                                     m_axis_tready,
  output logic                                     ovf_sticky,
  output logic [15:0]                              drop_cnt,
  output logic [31:0]                              pkt_seq
);

  localparam int ARR_W = ADC_DATA_WIDTH * N_ADC_CHANNELS;
  localparam int SET_W = 2 * ARR_W;
  localparam int CNT_W = $clog2(PKT_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_SAMPLES - 1);

  function automatic logic [C_DATA_WIDTH-1:0] sext_words(input logic [ARR_W-1:0] arr);
    logic [C_DATA_WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < N_ADC_CHANNELS; k++)
      w[k*WORD_W +: WORD_W] = {{(WORD_W-ADC_DATA_WIDTH){arr[k*ADC_DATA_WIDTH+ADC_DATA_WIDTH-1]}},
                               arr[k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]};
    return w;
  endfunction

  pk_state_t               state_q, state_d;
  logic [C_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [CNT_W-1:0]        in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [31:0]             samp_idx_q, samp_idx_d, pkt_seq_q, pkt_seq_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic                    ovf_q, ovf_d;

  logic             acc_gate, drop, hs;
  logic             fifo_wr, fifo_pop, fifo_full, fifo_empty, fifo_multi;
  logic [SET_W-1:0] fifo_head;
  logic [ARR_W-1:0] fifo_peek_a;

  sample_fifo #(.W(SET_W), .DEPTH(FIFO_DEPTH), .PEEK_W(ARR_W)) u_fifo (
    .clk          (axi_aclk),
    .rst          (rst),
    .wr_en        (fifo_wr),
    .wr_data      ({adc_b_data_arr, adc_a_data_arr}),
    .rd_en        (fifo_pop),
    .rd_data      (fifo_head),
    .rd_peek      (fifo_peek_a),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .more_than_one(fifo_multi)
  );

  // Once a packet has started filling, it keeps accepting until complete.
  always_comb begin
    acc_gate   = sample_valid && (acq_en || (in_cnt_q != '0));
    fifo_wr    = acc_gate && (!fifo_full || fifo_pop);
    drop       = acc_gate && fifo_full && !fifo_pop;
    in_cnt_d   = in_cnt_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (fifo_wr) in_cnt_d = (in_cnt_q == LAST_CNT) ? '0 : in_cnt_q + CNT_W'(1);
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = ovf_clr ? 16'd1 :
                   (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
    end else if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // samp_idx tracks the set at the FIFO head, i.e. its accept-order index.
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    out_cnt_d  = out_cnt_q;
    samp_idx_d = samp_idx_q;
    pkt_seq_d  = pkt_seq_q;
    fifo_pop   = 1'b0;
    hs         = tvalid_q && m_axis_tready;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        state_d   = HDR;
        tvalid_d  = 1'b1;
        tlast_d   = 1'b0;
        out_cnt_d = '0;
        tdata_d   = {ovf_q, 15'b0, drop_cnt_q, samp_idx_q, pkt_seq_q, HDR_MAGIC};
      end
      HDR: if (hs) begin
        state_d = PAY_A;
        tdata_d = sext_words(fifo_head[ARR_W-1:0]);
      end
      PAY_A: begin
        if (!tvalid_q) begin
          if (!fifo_empty) begin
            tvalid_d = 1'b1;
            tdata_d  = sext_words(fifo_head[ARR_W-1:0]);
          end
        end else if (hs) begin
          state_d = PAY_B;
          tdata_d = sext_words(fifo_head[SET_W-1:ARR_W]);
          tlast_d = (out_cnt_q == LAST_CNT);
        end
      end
      PAY_B: if (hs) begin
        fifo_pop   = 1'b1;
        samp_idx_d = samp_idx_q + 32'd1;
        tlast_d    = 1'b0;
        if (out_cnt_q != LAST_CNT) begin
          state_d   = PAY_A;
          out_cnt_d = out_cnt_q + CNT_W'(1);
          tvalid_d  = fifo_multi;
          if (fifo_multi) tdata_d = sext_words(fifo_peek_a);
        end else begin
          state_d   = IDLE;
          tvalid_d  = 1'b0;
          pkt_seq_d = pkt_seq_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q    <= IDLE;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      samp_idx_q <= '0;
      pkt_seq_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      samp_idx_q <= samp_idx_d;
      pkt_seq_q  <= pkt_seq_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = '1;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign ovf_sticky    = ovf_q;
  assign drop_cnt      = drop_cnt_q;
  assign pkt_seq       = pkt_seq_q;

endmodule
